// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings and constants for the EX-stage iterative multiply/divide unit.
package ex_muldiv_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Divide-by-zero leaves an all-ones quotient in LO.
    localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side bundle of the multiply/divide unit: operation request, MTHI/MTLO, HI/LO and hazard outputs.
interface ex_muldiv_unit_if #(parameter int WIDTH = 32);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             hilo_read;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, rs_val, rt_val, flush, hilo_read, hi_we, lo_we, wdata,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush, hilo_read, hi_we, lo_we, wdata,
        output hi, lo, busy, done, stall
    );

endinterface

// File: rtl/ex_muldiv_unit_datapath.sv
// Magnitude datapath: shift-add multiplier, restoring divider and sign-fix negators.
module muldiv_datapath
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             div0_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic               is_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic               div_q, neg_res_q, neg_rem_q;
    logic [WIDTH-1:0]   mcand_q, rem_q, quo_q;
    logic [2*WIDTH-1:0] prod_q;

    logic [WIDTH:0]     add_sum, shifted;
    logic               fits;
    logic [WIDTH-1:0]   rem_d, quo_d;
    logic [2*WIDTH-1:0] prod_d, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_div = op_is_div(op_i);
    assign a_neg  = op_is_signed(op_i) & a_i[WIDTH-1];
    assign b_neg  = op_is_signed(op_i) & b_i[WIDTH-1];
    assign a_mag  = a_neg ? -a_i : a_i;
    assign b_mag  = b_neg ? -b_i : b_i;
    assign div0_o = is_div & (b_i == '0);

    // One multiplier bit per step (LSB first); the carry lands in the top bit of the accumulator.
    assign add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_d  = {add_sum, prod_q[WIDTH-1:1]};

    // Restoring divide: the shifted partial remainder needs WIDTH+1 bits before the trial subtract.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, mcand_q});
    assign rem_d   = fits ? (shifted[WIDTH-1:0] - mcand_q) : shifted[WIDTH-1:0];
    assign quo_d   = {quo_q[WIDTH-2:0], fits};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mcand_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            prod_q    <= '0;
        end else if (load_i) begin
            div_q     <= is_div;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            mcand_q   <= is_div ? b_mag : a_mag;
            prod_q    <= {{WIDTH{1'b0}}, b_mag};
            rem_q     <= '0;
            quo_q     <= a_mag;
            // A zero divisor preloads the raw dividend and all-ones quotient with no sign fix.
            if (div0_o) begin
                neg_res_q <= 1'b0;
                neg_rem_q <= 1'b0;
                rem_q     <= a_i;
                quo_q     <= WIDTH'(DIV0_LO);
            end
        end else if (step_i) begin
            if (div_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
            end else begin
                prod_q <= prod_d;
            end
        end
    end

    assign prod_fix = neg_res_q ? -prod_q : prod_q;
    assign quo_fix  = neg_res_q ? -quo_q : quo_q;
    assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

    assign hi_o = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_o = div_q ? quo_fix : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: sequencing FSM, HI/LO architectural registers and hazard stall.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic           clock,
    input  logic           reset,
    ex_muldiv_unit_if.slave bus
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;

    logic             busy, accept, div0;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign busy   = (state_q != ST_IDLE);
    assign accept = (state_q == ST_IDLE) & bus.start & ~bus.flush;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock  (clock),
        .reset  (reset),
        .load_i (accept),
        .step_i (state_q == ST_CALC),
        .op_i   (op_e'(bus.op)),
        .a_i    (bus.rs_val),
        .b_i    (bus.rt_val),
        .div0_o (div0),
        .hi_o   (res_hi),
        .lo_o   (res_lo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_q   <= '0;
                        state_q <= div0 ? ST_FIX : ST_CALC;
                    end
                end
                ST_CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // MTHI/MTLO only land while idle; a result write in FIX always wins.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == ST_FIX) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end else if (state_q == ST_IDLE) begin
            if (bus.hi_we) hi_d = bus.wdata;
            if (bus.lo_we) lo_d = bus.wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.stall = busy & (bus.start | bus.hilo_read | bus.hi_we | bus.lo_we);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed literal cases plus randomized traffic against an arithmetic model.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    ex_muldiv_unit_if #(.WIDTH(W)) bus();

    ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one operation, from plain integer arithmetic.
    function automatic void computeModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                         output logic [31:0] h, output logic [31:0] l, output int lat);
        logic [63:0] p;
        longint      sa, sb, q, r;
        logic [63:0] qv, rv;
        p = '0; lat = 33; h = '0; l = '0;
        if (o == 2'b00) begin
            p = longint'($signed(a)) * longint'($signed(b));
            h = p[63:32]; l = p[31:0];
        end else if (o == 2'b01) begin
            p = {32'b0, a} * {32'b0, b};
            h = p[63:32]; l = p[31:0];
        end else if (b == 32'd0) begin
            h = a; l = 32'hFFFFFFFF; lat = 1;
        end else if (o == 2'b10) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = sa / sb; r = sa % sb;
            qv = q; rv = r;
            l = qv[31:0]; h = rv[31:0];
        end else begin
            l = a / b; h = a % b;
        end
    endfunction

    logic [31:0] mHi, mLo, pHi, pLo;
    int          mLeft;
    bit          mDone;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mHi = '0; mLo = '0; mLeft = 0; mDone = 0;
        end else begin
            mDone = 0;
            if (mLeft > 0) begin
                mLeft--;
                if (mLeft == 0) begin
                    mHi = pHi; mLo = pLo; mDone = 1;
                end
            end else begin
                if (bus.hi_we) mHi = bus.wdata;
                if (bus.lo_we) mLo = bus.wdata;
                if (bus.start && !bus.flush)
                    computeModel(bus.op, bus.rs_val, bus.rt_val, pHi, pLo, mLeft);
            end
        end
    end

    always @(negedge clock) begin
        checkOutput("cmp hi", bus.hi, mHi);
        checkOutput("cmp lo", bus.lo, mLo);
        checkOutput("cmp busy", bus.busy, mLeft > 0);
        checkOutput("cmp done", bus.done, mDone);
        checkOutput("cmp stall", bus.stall,
                    (mLeft > 0) && (bus.start || bus.hilo_read || bus.hi_we || bus.lo_we));
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic applyStimulus(input string name, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expHi,
                                 input logic [31:0] expLo, input int expBusy);
        int n;
        bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        waitIdle(n);
        checkOutput({name, " busy cycles"}, n, expBusy);
        checkOutput({name, " done"}, bus.done, 1'b1);
        checkOutput({name, " hi"}, bus.hi, expHi);
        checkOutput({name, " lo"}, bus.lo, expLo);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] h, l;
        int          lat, n;
        bit          seenDone;

        bus.start = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0; bus.flush = 0;
        bus.hilo_read = 0; bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;

        repeat (3) step();
        checkOutput("reset hi", bus.hi, 0);
        checkOutput("reset lo", bus.lo, 0);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset done", bus.done, 0);
        reset = 1'b1;
        step();

        computeModel(2'b10, 32'h80000000, 32'hFFFFFFFF, h, l, lat);
        checkOutput("model ovf lo", l, 32'h80000000);
        checkOutput("model ovf hi", h, 32'h0);
        computeModel(2'b11, 32'h12345678, 32'h0, h, l, lat);
        checkOutput("model div0 lat", lat, 1);
        checkOutput("model div0 hi", h, 32'h12345678);

        applyStimulus("mult", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 33);
        applyStimulus("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 33);

        // Second start issued in the done cycle must be accepted.
        bus.op = OP_DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd7; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checkOutput("b2b busy", bus.busy, 1);
        waitIdle(n);
        checkOutput("b2b hi", bus.hi, 32'd2);
        checkOutput("b2b lo", bus.lo, 32'd14);

        applyStimulus("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        applyStimulus("divu0", OP_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1);
        applyStimulus("div0 neg", OP_DIV, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, 1);
        applyStimulus("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);

        // hilo_read mid-flight stalls until done; an MTHI while busy is dropped.
        bus.op = OP_MULT; bus.rs_val = 32'd7; bus.rt_val = 32'd9; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
        step();
        bus.hi_we = 1'b0;
        repeat (3) step();
        bus.hilo_read = 1'b1;
        #1;
        checkOutput("hilo stall", bus.stall, 1);
        waitIdle(n);
        #1;
        checkOutput("hilo stall done", bus.stall, 0);
        checkOutput("hilo hi", bus.hi, 32'd0);
        checkOutput("hilo lo", bus.lo, 32'd63);
        bus.hilo_read = 1'b0;

        // MTHI with an accepted start: write lands, then FIX overwrites.
        bus.op = OP_MULTU; bus.rs_val = 32'd2; bus.rt_val = 32'd3; bus.start = 1'b1;
        bus.hi_we = 1'b1; bus.wdata = 32'h55;
        step();
        bus.start = 1'b0; bus.hi_we = 1'b0;
        checkOutput("mthi+start hi", bus.hi, 32'h55);
        waitIdle(n);
        checkOutput("mthi+start final hi", bus.hi, 32'd0);
        checkOutput("mthi+start final lo", bus.lo, 32'd6);

        bus.op = OP_MULT; bus.start = 1'b1; bus.flush = 1'b1;
        step();
        bus.start = 1'b0; bus.flush = 1'b0;
        checkOutput("flush busy", bus.busy, 0);

        bus.lo_we = 1'b1; bus.wdata = 32'h1234;
        step();
        bus.lo_we = 1'b0;
        checkOutput("mtlo lo", bus.lo, 32'h1234);

        // Reset in the middle of a divide aborts it without a done pulse.
        bus.hi_we = 1'b1; bus.wdata = 32'hAA;
        step();
        bus.hi_we = 1'b0;
        checkOutput("mthi hi", bus.hi, 32'hAA);
        bus.op = OP_DIV; bus.rs_val = 32'd1000; bus.rt_val = 32'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        #1 reset = 1'b0;
        #1;
        checkOutput("abort hi", bus.hi, 0);
        checkOutput("abort lo", bus.lo, 0);
        checkOutput("abort busy", bus.busy, 0);
        step();
        reset = 1'b1;
        seenDone = 0;
        repeat (40) begin
            step();
            seenDone |= bus.done;
        end
        checkOutput("abort no done", seenDone, 0);

        repeat (2500) begin
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.op        = 2'($urandom_range(0, 3));
            bus.rs_val    = pickOperand();
            bus.rt_val    = pickOperand();
            bus.flush     = ($urandom_range(0, 7) == 0);
            bus.hilo_read = ($urandom_range(0, 5) == 0);
            bus.hi_we     = ($urandom_range(0, 9) == 0);
            bus.lo_we     = ($urandom_range(0, 9) == 0);
            bus.wdata     = $urandom;
            step();
        end
        bus.start = 0; bus.flush = 0; bus.hilo_read = 0; bus.hi_we = 0; bus.lo_we = 0;
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
